d_hazard_scoreboard: RTL and testbench

// - Parametrised D-stage hazard unit that sits beside the D-stage decode controller, which supplies rs/rt Tuse, Tnew and mult/div class.
// - Keeps a shift-register scoreboard of in-flight destination registers (E..W) and a mult/div busy counter.
// - Produces the D-stage stall and per-operand forwarding selects.
// - Generalises the fixed 3-stage Tuse/Tnew stall logic to NUM_STAGES and configurable mult/div latency.

---
 rtl/d_hazard_scoreboard.sv | 158 +++++++++++++++
 tb/tb_d_hazard_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/d_hazard_scoreboard.sv
// rtl/d_hazard_scoreboard.sv - D-stage hazard scoreboard: stall, forwarding selects, mult/div busy tracking (optional HAZARD_STATS_EN adds stall_cnt)

module d_hazard_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int MUL_LAT    = 5,
    parameter int DIV_LAT    = 10,
    parameter int CNT_W      = 4,
    parameter int SEL_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_rs_tuse,
    input  logic [1:0]       d_rt_tuse,
    input  logic [4:0]       d_wr_addr,
    input  logic [1:0]       d_tnew,
    input  logic             d_md_start,
    input  logic             d_md_div,
    input  logic             d_md_use,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel,
    output logic             md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    // Tuse encoding 3 marks an operand that is not read at all.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);

    // Scoreboard entries: index 0 is the instruction now in E, the last index is W.
    logic       ent_valid [NUM_STAGES];
    logic [4:0] ent_addr  [NUM_STAGES];
    logic [1:0] ent_tnew  [NUM_STAGES];

    // Set while entry 0 holds a mult/div that has just started, so a HI/LO
    // reader right behind it stalls even before the busy counter is visible.
    logic md_e0;

    logic [CNT_W-1:0] busy_cnt;

    logic rs_hazard;
    logic rt_hazard;
    logic md_hazard;
    logic d_issue;
    logic md_launch;

    // Operand hazard search: any live producer whose result arrives too late for the reader.
    always_comb begin
        rs_hazard = 1'b0;
        rt_hazard = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (ent_valid[k] && (ent_addr[k] != 5'd0)) begin
                if ((d_rs_tuse != TUSE_NONE) && (ent_addr[k] == d_rs) &&
                    (ent_tnew[k] > d_rs_tuse)) begin
                    rs_hazard = 1'b1;
                end
                if ((d_rt_tuse != TUSE_NONE) && (ent_addr[k] == d_rt) &&
                    (ent_tnew[k] > d_rt_tuse)) begin
                    rt_hazard = 1'b1;
                end
            end
        end
    end

    // HI/LO readers wait for the mult/div unit, including the cycle a start sits in E.
    always_comb begin
        md_hazard = d_md_use && (md_busy || md_e0);
        stall     = d_valid && (rs_hazard || rt_hazard || md_hazard);
        d_issue   = d_valid && !stall;
        md_launch = d_issue && d_md_start;
    end

    // Forward select: scan oldest to youngest so the youngest ready match wins.
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (ent_valid[k] && (ent_addr[k] != 5'd0) && (ent_tnew[k] == 2'd0)) begin
                if (ent_addr[k] == d_rs) begin
                    fwd_rs_sel = SEL_W'(k + 1);
                end
                if (ent_addr[k] == d_rt) begin
                    fwd_rt_sel = SEL_W'(k + 1);
                end
            end
        end
    end

    // Shift the scoreboard one stage per clock; D loads entry 0 or a bubble when stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                ent_valid[k] <= 1'b0;
                ent_addr[k]  <= 5'd0;
                ent_tnew[k]  <= 2'd0;
            end
        end else begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1] && !flush;
                ent_addr[k]  <= ent_addr[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == 2'd0) ? 2'd0 : ent_tnew[k-1] - 2'd1;
            end
            if (stall) begin
                ent_valid[0] <= 1'b0;
                ent_addr[0]  <= 5'd0;
                ent_tnew[0]  <= 2'd0;
            end else begin
                ent_valid[0] <= d_valid && (d_wr_addr != 5'd0) && !flush;
                ent_addr[0]  <= d_wr_addr;
                ent_tnew[0]  <= d_tnew;
            end
        end
    end

    // Entry-0 mult/div marker travels with the instruction it describes and dies on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_e0 <= 1'b0;
        end else begin
            md_e0 <= md_launch && !flush;
        end
    end

    // Busy counter: load the unit latency on launch, then count down to zero.
    // Flush leaves it alone because the HI/LO unit keeps running regardless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt <= '0;
        end else if (md_launch) begin
            busy_cnt <= d_md_div ? DIV_LOAD : MUL_LOAD;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end

    assign md_busy = (busy_cnt != '0);

`ifdef HAZARD_STATS_EN
    // Saturating count of stalled cycles; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// tb/tb_d_hazard_scoreboard.sv - table-driven and directed checks for d_hazard_scoreboard

module tb_d_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_rs_tuse;
    logic [1:0] d_rt_tuse;
    logic [4:0] d_wr_addr;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks;
    int n_err;

    d_hazard_scoreboard #(
        .NUM_STAGES(3),
        .MUL_LAT(5),
        .DIV_LAT(10),
        .CNT_W(4),
        .SEL_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .d_valid(d_valid),
        .d_rs(d_rs),
        .d_rt(d_rt),
        .d_rs_tuse(d_rs_tuse),
        .d_rt_tuse(d_rt_tuse),
        .d_wr_addr(d_wr_addr),
        .d_tnew(d_tnew),
        .d_md_start(d_md_start),
        .d_md_div(d_md_div),
        .d_md_use(d_md_use),
        .flush(flush),
        .stall(stall),
        .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] rs_tuse;
        logic [1:0] rt_tuse;
        logic [4:0] wr;
        logic [1:0] tnew;
        logic       chk_sel;
        logic       exp_stall;
        logic [1:0] exp_rs_sel;
        logic [1:0] exp_rt_sel;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] rs_tuse, input logic [1:0] rt_tuse,
                         input logic [4:0] wr, input logic [1:0] tnew,
                         input logic mds, input logic mdd, input logic mdu, input logic fl);
        d_valid    = v;
        d_rs       = rs;
        d_rt       = rt;
        d_rs_tuse  = rs_tuse;
        d_rt_tuse  = rt_tuse;
        d_wr_addr  = wr;
        d_tnew     = tnew;
        d_md_start = mds;
        d_md_div   = mdd;
        d_md_use   = mdu;
        flush      = fl;
    endtask

    // Change inputs on the falling edge and settle before sampling.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] rs_tuse, input logic [1:0] rt_tuse,
                        input logic [4:0] wr, input logic [1:0] tnew,
                        input logic mds, input logic mdd, input logic mdu, input logic fl);
        @(negedge clk);
        drive(v, rs, rt, rs_tuse, rt_tuse, wr, tnew, mds, mdd, mdu, fl);
        #1;
    endtask

    task automatic add_vec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [1:0] rs_tuse, input logic [1:0] rt_tuse,
                           input logic [4:0] wr, input logic [1:0] tnew, input logic chk_sel,
                           input logic es, input logic [1:0] ers, input logic [1:0] ert);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.rs_tuse = rs_tuse; t.rt_tuse = rt_tuse;
        t.wr = wr; t.tnew = tnew; t.chk_sel = chk_sel;
        t.exp_stall = es; t.exp_rs_sel = ers; t.exp_rt_sel = ert;
        vecs.push_back(t);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //        v  rs  rt  rsT rtT wr tnew chk stall rsS rtS
        // lw $1 <- 0($2); add $5,$1,$6 stalls once on the load result
        add_vec(1, 2,  0,  1,  3,  1,  2,  1,  0,    0,  0);
        add_vec(1, 1,  6,  1,  1,  5,  1,  1,  1,    0,  0);
        add_vec(1, 1,  6,  1,  1,  5,  1,  0,  0,    0,  0);
        // ori $2; beq $2,$5 stalls once, then both operands forward (M and W)
        add_vec(1, 0,  0,  1,  3,  2,  1,  1,  0,    0,  0);
        add_vec(1, 2,  5,  0,  0,  0,  0,  0,  1,    0,  0);
        add_vec(1, 2,  5,  0,  0,  0,  0,  1,  0,    2,  3);
        // add $3; sw $3 needs no stall and no D forward
        add_vec(1, 0,  0,  1,  1,  3,  1,  1,  0,    0,  0);
        add_vec(1, 2,  3,  1,  2,  0,  0,  1,  0,    0,  0);
        add_vec(1, 3,  3,  0,  1,  0,  0,  1,  0,    2,  2);
        add_vec(1, 3,  0,  0,  0,  0,  0,  1,  0,    3,  0);
        // write $0 then read $0: never a hazard, never forwarded
        add_vec(1, 0,  0,  1,  3,  0,  2,  1,  0,    0,  0);
        add_vec(1, 0,  0,  0,  0,  0,  0,  1,  0,    0,  0);

        @(negedge clk);
        check("reset_stall", stall, 1'b0);
        check("reset_rs_sel", fwd_rs_sel, 2'd0);
        check("reset_rt_sel", fwd_rt_sel, 2'd0);
        check("reset_md_busy", md_busy, 1'b0);
`ifdef HAZARD_STATS_EN
        check("reset_stall_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rs_tuse, vecs[i].rt_tuse,
                 vecs[i].wr, vecs[i].tnew, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            if (vecs[i].chk_sel) begin
                check($sformatf("vec%0d_rs_sel", i), fwd_rs_sel, vecs[i].exp_rs_sel);
                check($sformatf("vec%0d_rt_sel", i), fwd_rt_sel, vecs[i].exp_rt_sel);
            end
        end

        // div then mflo: ten stalled cycles while the divider is busy
        step(1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0);
        check("div_issue_stall", stall, 1'b0);
        check("div_issue_busy", md_busy, 1'b0);
        step(1, 0, 0, 3, 3, 8, 1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("mflo_wait%0d_stall", i), stall, 1'b1);
            check($sformatf("mflo_wait%0d_busy", i), md_busy, 1'b1);
            @(negedge clk);
            #1;
        end
        check("mflo_release_stall", stall, 1'b0);
        check("mflo_release_busy", md_busy, 1'b0);

        // mult then mfhi: five stalled cycles
        step(1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0);
        check("mult_issue_stall", stall, 1'b0);
        step(1, 0, 0, 3, 3, 9, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("mfhi_wait%0d_stall", i), stall, 1'b1);
            @(negedge clk);
            #1;
        end
        check("mfhi_release_stall", stall, 1'b0);
        check("mfhi_release_busy", md_busy, 1'b0);

        // lw $4 flushed while in D; the older mfhi $9 is flushed too
        step(1, 0, 0, 1, 3, 4, 2, 0, 0, 0, 1);
        check("flush_cycle_stall", stall, 1'b0);
        step(1, 4, 9, 1, 0, 6, 1, 0, 0, 0, 0);
        check("post_flush_stall", stall, 1'b0);
        check("post_flush_rs_sel", fwd_rs_sel, 2'd0);
        check("post_flush_rt_sel", fwd_rt_sel, 2'd0);
`ifdef HAZARD_STATS_EN
        check("stall_cnt_total", stall_cnt, 32'd17);
`endif

        // flush and stall together: the stalled producer's bubble and all entries clear
        step(1, 0, 0, 3, 3, 11, 2, 0, 0, 0, 0);
        step(1, 11, 0, 0, 3, 0, 0, 0, 0, 0, 1);
        check("flush_stall_stall", stall, 1'b1);
        step(1, 11, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        check("flush_stall_after", stall, 1'b0);

        // asynchronous reset in the middle of a stall with the multiplier busy
        step(1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 1, 3, 10, 2, 0, 0, 0, 0);
        step(1, 10, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        check("pre_reset_stall", stall, 1'b1);
        check("pre_reset_busy", md_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("async_reset_stall", stall, 1'b0);
        check("async_reset_busy", md_busy, 1'b0);
`ifdef HAZARD_STATS_EN
        check("async_reset_stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        step(1, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        check("after_reset_stall", stall, 1'b0);
        check("after_reset_rs_sel", fwd_rs_sel, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
